// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector: loadable pattern/length/overlap,
// registered Moore match flag and a saturating match counter.
module seq_detector_prog #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               x,
   input  logic               in_valid,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] pat,
   input  logic [LEN_W-1:0]   pat_len,
   input  logic               overlap,
   input  logic               clr_count,
   output logic               match,
   output logic [CNT_W-1:0]   match_count,
   output logic               cfg_err
);

   localparam int                FILL_W   = $clog2(MAX_LEN + 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MAX_LEN);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   logic [MAX_LEN-1:0] act_pat;
   logic [LEN_W-1:0]   act_len;
   logic               act_overlap;
   logic [MAX_LEN-1:0] hist;
   logic [FILL_W-1:0]  fill;

   logic [MAX_LEN-1:0] new_hist;
   logic [MAX_LEN-1:0] len_mask;
   logic [FILL_W-1:0]  fill_inc;
   logic               accept;
   logic               fill_ok;
   logic               hit;

   // A config load takes priority over the data bit presented on the same edge.
   assign accept   = in_valid && !cfg_load && !cfg_err;
   assign new_hist = {hist[MAX_LEN-2:0], x};
   assign fill_ok  = (32'(fill) + 32'd1) >= 32'(act_len);
   assign fill_inc = (fill == FILL_MAX) ? FILL_MAX : fill + FILL_W'(1);
   assign hit      = accept && fill_ok && ((new_hist & len_mask) == (act_pat & len_mask));

   // NOTE: every always_comb output gets a default before any conditional
   // assignment so no latch is inferred.
   always_comb begin
      len_mask = '0;
      for (int i = 0; i < MAX_LEN; i++) len_mask[i] = (i < int'(act_len));
   end

   // NOTE: state is updated with non-blocking assignments only, so every
   // right-hand side sees the pre-edge value regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         act_pat     <= '0;
         act_len     <= '0;
         act_overlap <= 1'b0;
         cfg_err     <= 1'b1;
         hist        <= '0;
         fill        <= '0;
         match       <= 1'b0;
         match_count <= '0;
      end else begin
         if (cfg_load) begin
            act_pat     <= pat;
            act_len     <= pat_len;
            act_overlap <= overlap;
            cfg_err     <= (pat_len == '0) || (int'(pat_len) > MAX_LEN);
            hist        <= '0;
            fill        <= '0;
            match       <= 1'b0;
         end else if (accept) begin
            hist  <= new_hist;
            match <= hit;
            // Non-overlapping mode restarts the fill so the next hit needs L fresh bits.
            fill  <= (hit && !act_overlap) ? '0 : fill_inc;
         end

         if (clr_count)
            match_count <= '0;
         else if (hit && match_count != CNT_MAX)
            match_count <= match_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_seq_detector_prog.sv
// Scoreboard bench for seq_detector_prog: a bit-list reference model feeds an expected
// queue; a monitor compares two DUT instances (CNT_W=8 and CNT_W=2) after each event.
module tb_seq_detector_prog;

   localparam int MAX_LEN = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       x = 1'b0, in_valid = 1'b0, cfg_load = 1'b0, overlap = 1'b0, clr_count = 1'b0;
   logic [7:0] pat = '0;
   logic [3:0] pat_len = '0;

   logic       match_a, err_a, match_b, err_b;
   logic [7:0] count_a;
   logic [1:0] count_b;

   seq_detector_prog #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .cfg_load(cfg_load),
      .pat(pat), .pat_len(pat_len), .overlap(overlap), .clr_count(clr_count),
      .match(match_a), .match_count(count_a), .cfg_err(err_a));

   seq_detector_prog #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .cfg_load(cfg_load),
      .pat(pat), .pat_len(pat_len), .overlap(overlap), .clr_count(clr_count),
      .match(match_b), .match_count(count_b), .cfg_err(err_b));

   always #5 clk = ~clk;

   typedef struct {
      logic       match;
      logic [7:0] cnt;
      logic [1:0] cnt2;
      logic       err;
   } exp_t;

   exp_t exp_q[$];
   event sample_ev;
   int   n_cmp = 0;
   int   n_err = 0;

   // Reference model: list of accepted bits plus count of bits since the last clear.
   logic [7:0] m_pat;
   int         m_len;
   bit         m_ovl, m_err, m_match;
   int         m_cnt, m_cnt2, m_fresh;
   bit         m_bits[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pat = '0; m_len = 0; m_ovl = 0; m_err = 1; m_match = 0;
      m_cnt = 0; m_cnt2 = 0; m_fresh = 0;
      m_bits.delete();
   endtask

   task automatic push_expected();
      exp_t e;
      e.match = m_match; e.cnt = 8'(m_cnt); e.cnt2 = 2'(m_cnt2); e.err = m_err;
      exp_q.push_back(e);
      -> sample_ev;
   endtask

   task automatic model_edge(input bit xi, vi, li, input logic [7:0] pi, input int leni,
                             input bit oi, ci);
      bit hit = 0;
      if (li) begin
         m_pat = pi; m_len = leni; m_ovl = oi;
         m_err = (leni == 0) || (leni > MAX_LEN);
         m_bits.delete(); m_fresh = 0; m_match = 0;
      end else if (vi && !m_err) begin
         m_bits.push_back(xi);
         if (m_bits.size() > 40) void'(m_bits.pop_front());
         m_fresh++;
         if (m_fresh >= m_len) begin
            hit = 1;
            // Last received bit pairs with pat[0], first of the window with pat[L-1].
            for (int k = 0; k < m_len; k++)
               if (m_bits[m_bits.size() - 1 - k] != m_pat[k]) hit = 0;
         end
         m_match = hit;
         if (hit && !m_ovl) m_fresh = 0;
      end
      if (ci) begin
         m_cnt = 0; m_cnt2 = 0;
      end else if (hit) begin
         m_cnt  = (m_cnt  < 255) ? m_cnt  + 1 : 255;
         m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
      end
   endtask

   task automatic step(input bit xi, vi, li, input logic [7:0] pi, input int leni,
                       input bit oi, ci);
      @(negedge clk);
      rst = 1'b1; x = xi; in_valid = vi; cfg_load = li;
      pat = pi; pat_len = 4'(leni); overlap = oi; clr_count = ci;
      @(posedge clk);
      model_edge(xi, vi, li, pi, leni, oi, ci);
      push_expected();
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b0; x = 1'b1; in_valid = 1'b1; cfg_load = 1'b1;
      pat = 8'h03; pat_len = 4'd2; overlap = 1'b1; clr_count = 1'b0;
      model_reset();
      push_expected();
      @(posedge clk);
      push_expected();
   endtask

   task automatic load(input logic [7:0] pi, input int leni, input bit oi);
      step(1'b1, 1'b1, 1'b1, pi, leni, oi, 1'b0);
   endtask

   task automatic send(input bit b);
      step(b, 1'b1, 1'b0, 8'($urandom), int'($urandom_range(0, 15)), 1'b0, 1'b0);
   endtask

   task automatic idle();
      step(1'($urandom), 1'b0, 1'b0, 8'($urandom), 0, 1'b0, 1'b0);
   endtask

   task automatic send_seq(input logic [31:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) send(bits[i]);
   endtask

   // Monitor: outputs settle 1 time unit after each clock edge or reset event.
   initial begin
      exp_t e;
      forever begin
         @(sample_ev);
         #1;
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("match",       32'(match_a), 32'(e.match));
            check("match_count", 32'(count_a), 32'(e.cnt));
            check("cfg_err",     32'(err_a),   32'(e.err));
            check("match_w2",    32'(match_b), 32'(e.match));
            check("count_w2",    32'(count_b), 32'(e.cnt2));
            check("cfg_err_w2",  32'(err_b),   32'(e.err));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      pulse_reset();
      send_seq(32'b101, 3);                   // disabled: no match before first load

      load(8'b1001, 4, 1'b0);                 // non-overlapping
      send_seq(32'b1001001, 7);
      load(8'b1001, 4, 1'b1);                 // overlapping
      send_seq(32'b1001001, 7);

      load(8'b1001, 4, 1'b0);                 // match holds across idle cycles
      send_seq(32'b100, 3);
      repeat (5) idle();
      send(1'b1);
      repeat (3) idle();
      send(1'b0);

      load(8'hFF, 0, 1'b1);                   // invalid lengths
      send_seq(32'hFF, 8);
      load(8'hFF, MAX_LEN + 1, 1'b1);
      send_seq(32'h1FF, 9);
      load(8'hFF, MAX_LEN, 1'b1);             // full-length pattern
      send_seq(32'h1FF, 9);

      step(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1);
      load(8'b11, 2, 1'b1);                   // saturation of the narrow counter
      send_seq(32'h3F, 6);
      step(1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1);  // clear wins over a hit
      send(1'b1);

      load(8'b1001, 4, 1'b0);                 // load mid-pattern discards the bit
      send_seq(32'b100, 3);
      step(1'b1, 1'b1, 1'b1, 8'b1001, 4, 1'b0, 1'b0);
      send(1'b1);
      send_seq(32'b001, 3);
      send_seq(32'b10, 2);
      pulse_reset();                          // reset mid-stream drops config
      send_seq(32'b1001, 4);

      for (int r = 0; r < 30; r++) begin
         int v = int'($urandom_range(0, 9));
         int l = (v == 0) ? 0 : (v == 9) ? 9 : int'($urandom_range(2, 4));
         load(8'($urandom), l, 1'($urandom));
         for (int c = 0; c < 40; c++) begin
            int roll = int'($urandom_range(0, 199));
            if (roll == 0) begin
               pulse_reset();
               load(8'($urandom), int'($urandom_range(1, 4)), 1'($urandom));
            end else begin
               step(1'($urandom), $urandom_range(0, 3) != 0, roll < 3, 8'($urandom),
                    int'($urandom_range(1, 5)), 1'($urandom), $urandom_range(0, 31) == 0);
            end
         end
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
Runtime-programmable serial pattern detector. It is the parametrised successor to the fixed-pattern Moore detectors. Pattern, pattern length and overlap mode are loaded through a config strobe. Input bits are qualified by in_valid. The Moore-style registered match flag and a saturating match counter feed the status/debug path.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..32)
LEN_W, 4, width of pat_len; must hold MAX_LEN
CNT_W, 8, width of match_count

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
x  in  1  serial data bit
in_valid  in  1  x is accepted on this clock edge
cfg_load  in  1  latch pat/pat_len/overlap into active config
pat  in  MAX_LEN  pattern; bit pat[pat_len-1] is the first-received bit, pat[0] the last
pat_len  in  LEN_W  pattern length in bits
overlap  in  1  1 = overlapping detection, 0 = non-overlapping
clr_count  in  1  synchronous clear of match_count
match  out  1  registered Moore match flag
match_count  out  CNT_W  number of matches, saturating
cfg_err  out  1  active config invalid; detector disabled

Behaviour:
- Reset is asserted with rst=0, asynchronous.
  - Active config resets to pat=0, len=0, overlap=0, so cfg_err=1 and the block stays disabled until the first cfg_load.
  - History shift register, fill counter, match, match_count all reset to 0.
- Internal state:
  - hist[MAX_LEN-1:0]: shift register; a new bit enters at bit 0.
  - fill: saturating at MAX_LEN; the number of valid bits since the last clear.
- Config load: on a clock edge with cfg_load=1:
  - Latch pat, pat_len and overlap.
  - Clear hist, fill and match. match_count is kept.
  - cfg_err <= (pat_len==0 || pat_len>MAX_LEN).
  - If in_valid is also 1 that cycle, the bit is discarded (cfg_load wins).
- Accepted bit: on a clock edge with in_valid=1, cfg_load=0, cfg_err=0:
  - hist <= {hist[MAX_LEN-2:0], x}.
  - fill <= min(fill+1, MAX_LEN).
  - Let L = active length, and hit = (fill+1 >= L) && (new hist[L-1:0] == pat[L-1:0]).
  - match <= hit.
  - If hit and overlap=0: fill <= 0. hist keeps shifting; the cleared fill guarantees L fresh bits before the next hit.
  - If hit and overlap=1: fill keeps incrementing, so the pattern suffix can seed the next match.
- Idle edges: with in_valid=0 (and no cfg_load), hist, fill and match hold.
  - Moore semantics: match stays high until the next accepted bit or a cfg_load.
- Latency: match rises on the clock edge that accepts the completing bit. It is visible in the following cycle. No combinational path from x to match.
- cfg_err=1: in_valid is ignored and match=0.
- Match counter:
  - Increments by 1 on each edge where hit=1.
  - Saturates at 2^CNT_W-1, with no wrap.
  - If clr_count and hit occur on the same edge, the counter is cleared (clr_count wins) and the hit is not counted.
- Reset mid-stream: immediate return to reset state. The stale config is not retained.
- No handshake back-pressure: the block accepts every valid bit.

Test Plan:
- Reset, then cfg pat=4'b1001, len=4, overlap=0; stream 1,0,0,1,0,0,1 (all valid) -> match high only after bit 4; match_count=1.
- Same stream with overlap=1 -> match after bits 4 and 7, low in between; match_count=2.
- len=4, pat 1001, stream 1,0,0 then in_valid=0 for 5 cycles, then 1 -> match asserts only after the 4th valid bit and holds high through the following idle cycles until the next valid bit (0) clears it.
- cfg_load with pat_len=0, then pat_len=MAX_LEN+1 -> cfg_err=1, match stays 0 on any stream. Then load len=MAX_LEN, pat=all-ones; stream 8 ones -> cfg_err=0, match after the 8th one; a 9th one with overlap=1 -> second match.
- CNT_W=2, overlap=1, pat=2'b11 len=2; stream 6 ones -> count 1,2,3,3,3 (saturates). Assert clr_count together with a hit -> count=0.
- Mid-pattern: after stream 1,0,0, assert cfg_load (with in_valid=1, x=1) -> bit discarded, fill cleared; a further 1 does not match. Separately, pulse rst low mid-stream -> all outputs 0, cfg_err=1.
